pkt_encoder: RTL and testbench

Parametrised multi-source packet framer feeding the byte-wide UART/link transmitter. It arbitrates among N_SRC show-ahead message FIFOs and frames one whole message per grant as PREFIX, ADDR, source id, length (1 or 2 bytes), data, checksum. It supports selectable arbitration and checksum modes, 16-bit lengths and zero-length messages, and uses a true valid/ready output handshake at one byte per cycle.

---
 rtl/pkt_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_pkt_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_encoder.sv
// Multi-source packet framer: arbitrates among show-ahead message FIFOs and emits
// PREFIX, ADDR, source id, length, data, checksum over a one-byte valid/ready link.
module pkt_encoder #(
   parameter int         N_SRC     = 4,
   parameter int         LEN_BYTES = 1,
   parameter logic [7:0] PREFIX    = 8'hA5,
   parameter logic [7:0] ADDR      = 8'h01,
   parameter int         ARB_MODE  = 0,
   parameter int         CHK_MODE  = 0,
   localparam int        SRC_W     = (N_SRC > 2) ? $clog2(N_SRC) : 1,
   localparam int        LEN_W     = 8 * LEN_BYTES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_SRC-1:0]       have_msg_bus,
   input  logic [8*N_SRC-1:0]     data_bus,
   input  logic [LEN_W*N_SRC-1:0] len_bus,
   output logic [N_SRC-1:0]       rdreq_bus,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic [SRC_W-1:0]       cur_src
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREFIX_S = 3'd1,
      ADDR_S   = 3'd2,
      SRC_S    = 3'd3,
      LEN_S    = 3'd4,
      DATA_S   = 3'd5,
      CHK_S    = 3'd6
   } state_t;

   localparam logic LEN2 = (LEN_BYTES == 2);

   state_t             state_r, state_nx_s;
   logic [7:0]         tx_data_r;
   logic               tx_valid_r;
   logic [SRC_W-1:0]   cur_src_r, last_grant_r;
   logic [LEN_W-1:0]   len_r, cnt_r, grant_len_s;
   logic [7:0]         chk_r, chk_nx_s, head_s, byte_s;
   logic               len_pend_r;
   logic               load_en_s, load_s, grant_s, ld_data_s, ld_chk_s, set_pend_s, clr_pend_s;
   logic               grant_vld_s, hit_s;
   logic [SRC_W-1:0]   grant_idx_s, cand_s;

   function automatic logic [SRC_W-1:0] wrap_idx(input int v);
      int w;
      w = (v >= N_SRC) ? (v - N_SRC) : v;
      return w[SRC_W-1:0];
   endfunction

   assign load_en_s = !tx_valid_r || tx_ready;

   // Arbiter: rotating scan from last grant + 1, or plain lowest-index priority
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = {SRC_W{1'b0}};
      cand_s      = {SRC_W{1'b0}};
      hit_s       = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         cand_s      = (ARB_MODE == 1) ? SRC_W'(k) : wrap_idx(int'(last_grant_r) + 1 + k);
         hit_s       = !grant_vld_s && have_msg_bus[cand_s];
         grant_idx_s = hit_s ? cand_s : grant_idx_s;
         grant_vld_s = grant_vld_s | hit_s;
      end
   end

   // Source muxes: head byte of the granted FIFO and length of the winning request
   always_comb begin
      head_s      = 8'h00;
      grant_len_s = {LEN_W{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         head_s      = (cur_src_r == SRC_W'(i)) ? data_bus[8*i +: 8] : head_s;
         grant_len_s = (grant_idx_s == SRC_W'(i)) ? len_bus[LEN_W*i +: LEN_W] : grant_len_s;
      end
      chk_nx_s = (CHK_MODE == 1) ? (chk_r ^ head_s) : (chk_r + head_s);
   end

   // Framing FSM: state names the byte most recently placed in the output register
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      byte_s     = 8'h00;
      grant_s    = 1'b0;
      ld_data_s  = 1'b0;
      ld_chk_s   = 1'b0;
      set_pend_s = 1'b0;
      clr_pend_s = 1'b0;
      if (load_en_s) begin
         case (state_r)
            // CHK_S also arbitrates so back-to-back frames need no idle cycle
            IDLE, CHK_S: begin
               if (grant_vld_s) begin
                  load_s     = 1'b1;
                  byte_s     = PREFIX;
                  grant_s    = 1'b1;
                  state_nx_s = PREFIX_S;
               end else begin
                  state_nx_s = IDLE;
               end
            end
            PREFIX_S: begin
               load_s     = 1'b1;
               byte_s     = ADDR;
               state_nx_s = ADDR_S;
            end
            ADDR_S: begin
               load_s     = 1'b1;
               byte_s     = 8'(cur_src_r);
               state_nx_s = SRC_S;
            end
            SRC_S: begin
               load_s     = 1'b1;
               byte_s     = len_r[LEN_W-1 -: 8];
               set_pend_s = 1'b1;
               state_nx_s = LEN_S;
            end
            LEN_S: begin
               load_s = 1'b1;
               if (len_pend_r) begin
                  byte_s     = len_r[7:0];
                  clr_pend_s = 1'b1;
               end else if (len_r == {LEN_W{1'b0}}) begin
                  byte_s     = 8'h00;
                  ld_chk_s   = 1'b1;
                  state_nx_s = CHK_S;
               end else begin
                  byte_s     = head_s;
                  ld_data_s  = 1'b1;
                  state_nx_s = DATA_S;
               end
            end
            DATA_S: begin
               load_s = 1'b1;
               if (cnt_r == len_r) begin
                  byte_s     = chk_r;
                  ld_chk_s   = 1'b1;
                  state_nx_s = CHK_S;
               end else begin
                  byte_s    = head_s;
                  ld_data_s = 1'b1;
               end
            end
            default: state_nx_s = IDLE;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // State, output register, grant latch, data counter and checksum accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         tx_data_r    <= 8'h00;
         tx_valid_r   <= 1'b0;
         cur_src_r    <= {SRC_W{1'b0}};
         last_grant_r <= SRC_W'(N_SRC - 1);
         len_r        <= {LEN_W{1'b0}};
         cnt_r        <= {LEN_W{1'b0}};
         chk_r        <= 8'h00;
         len_pend_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         if (load_s) begin
            tx_data_r  <= byte_s;
            tx_valid_r <= 1'b1;
         end else if (tx_ready) begin
            tx_valid_r <= 1'b0;
         end
         if (grant_s) begin
            cur_src_r    <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            len_r        <= grant_len_s;
         end
         if (grant_s || ld_chk_s) begin
            cnt_r <= {LEN_W{1'b0}};
            chk_r <= 8'h00;
         end else if (ld_data_s) begin
            cnt_r <= cnt_r + LEN_W'(1);
            chk_r <= chk_nx_s;
         end
         if (set_pend_s) begin
            len_pend_r <= LEN2;
         end else if (clr_pend_s) begin
            len_pend_r <= 1'b0;
         end
      end
   end

   // Pop strobe is tied to the data load so exactly one pop accompanies each data byte
   assign rdreq_bus = ld_data_s ? ({{(N_SRC-1){1'b0}}, 1'b1} << cur_src_r) : {N_SRC{1'b0}};
   assign tx_data   = tx_data_r;
   assign tx_valid  = tx_valid_r;
   assign cur_src   = cur_src_r;
   assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_pkt_encoder.sv
// Directed bench for pkt_encoder: table-driven single-frame vectors plus
// arbitration, 16-bit length and mid-frame reset sequences.
module tb_pkt_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  have_msg;
   logic [31:0] data_bus;
   logic [31:0] len_bus;
   logic        tx_ready;

   logic [3:0]  rr_rdreq, fx_rdreq, l2_rdreq;
   logic [7:0]  rr_data, fx_data, l2_data;
   logic        rr_valid, fx_valid, l2_valid;
   logic        rr_busy, fx_busy, l2_busy;
   logic [1:0]  rr_src, fx_src, l2_src;
   logic [3:0]  l2_have;
   logic [63:0] l2_len;
   logic [31:0] l2_dbus;

   always #5 clk = ~clk;

   pkt_encoder #(.N_SRC(4), .LEN_BYTES(1), .ARB_MODE(0), .CHK_MODE(0)) u_rr (
      .clk(clk), .rst(rst), .have_msg_bus(have_msg), .data_bus(data_bus), .len_bus(len_bus),
      .rdreq_bus(rr_rdreq), .tx_data(rr_data), .tx_valid(rr_valid), .tx_ready(tx_ready),
      .busy(rr_busy), .cur_src(rr_src));

   pkt_encoder #(.N_SRC(4), .LEN_BYTES(1), .ARB_MODE(1), .CHK_MODE(0)) u_fx (
      .clk(clk), .rst(rst), .have_msg_bus(have_msg), .data_bus(data_bus), .len_bus(len_bus),
      .rdreq_bus(fx_rdreq), .tx_data(fx_data), .tx_valid(fx_valid), .tx_ready(tx_ready),
      .busy(fx_busy), .cur_src(fx_src));

   pkt_encoder #(.N_SRC(4), .LEN_BYTES(2), .ARB_MODE(0), .CHK_MODE(1)) u_l2 (
      .clk(clk), .rst(rst), .have_msg_bus(l2_have), .data_bus(l2_dbus), .len_bus(l2_len),
      .rdreq_bus(l2_rdreq), .tx_data(l2_data), .tx_valid(l2_valid), .tx_ready(tx_ready),
      .busy(l2_busy), .cur_src(l2_src));

   typedef struct {
      logic [1:0]  src;
      logic [7:0]  len;
      logic [23:0] data;
      bit          stall;
      int          n;
      logic [63:0] frame;
   } vec_t;

   vec_t        vecs[5];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  fifo_b[8];
   int          ptr;
   bit          use_fifo;
   int          act_src;
   logic [7:0]  got[$];
   logic [7:0]  fx_got[$];
   logic [7:0]  l2b[$];
   int          pops;
   int          gaps;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < 4; i++)
         data_bus[8*i +: 8] = (use_fifo && i == act_src) ? fifo_b[ptr] : (8'h40 + 8'(i));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; tx_ready = 1'b1; have_msg = 4'h0; l2_have = 4'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Collect bytes transferred by u_rr (and u_fx) until n bytes or the cycle budget runs out
   task automatic run_rr(input int n, input bit stall, input bit drop, input int stop_at);
      int k; bit held; bit popped; logic [7:0] hb;
      k = 0; held = 1'b0; popped = 1'b0; hb = 8'h00;
      got.delete(); fx_got.delete(); pops = 0; gaps = 0;
      while (got.size() < n && k < 3000) begin
         @(negedge clk);
         if (popped && ptr < 7) ptr++;
         drive_data();
         tx_ready = stall ? (k % 3 == 0) : 1'b1;
         #1;
         if (drop && rr_busy) have_msg[act_src] = 1'b0;
         if (stop_at > 0 && got.size() >= stop_at) have_msg = 4'h0;
         if (held) begin
            chk("hold_data", 32'(rr_data), 32'(hb));
            chk("hold_valid", 32'(rr_valid), 32'd1);
         end
         popped = (rr_rdreq != 4'b0000);
         if (popped) begin
            pops++;
            chk("rdreq_onehot", 32'($countones(rr_rdreq)), 32'd1);
            if (act_src >= 0) chk("rdreq_src", 32'(rr_rdreq), 32'(4'b0001 << act_src));
            chk("rdreq_on_load", 32'(!rr_valid || tx_ready), 32'd1);
         end
         if (rr_valid && tx_ready) got.push_back(rr_data);
         else if (got.size() > 0) gaps++;
         if (fx_valid && tx_ready) fx_got.push_back(fx_data);
         held = rr_valid && !tx_ready;
         hb   = rr_data;
         k++;
      end
      chk("frame_timeout", 32'(k >= 3000), 32'd0);
   endtask

   initial begin
      vecs[0] = '{src:2'd2, len:8'd3, data:24'h1E140A, stall:1'b0, n:8, frame:64'hA50102030A141E3C};
      vecs[1] = '{src:2'd2, len:8'd3, data:24'h1E140A, stall:1'b1, n:8, frame:64'hA50102030A141E3C};
      vecs[2] = '{src:2'd1, len:8'd0, data:24'h000000, stall:1'b0, n:5, frame:64'hA501010000000000};
      vecs[3] = '{src:2'd3, len:8'd2, data:24'h0002FF, stall:1'b0, n:7, frame:64'hA5010302FF020100};
      vecs[4] = '{src:2'd0, len:8'd1, data:24'h000080, stall:1'b1, n:6, frame:64'hA501000180800000};

      rst = 1'b1; have_msg = 4'h0; data_bus = 32'h0; len_bus = 32'h0; tx_ready = 1'b1;
      l2_have = 4'h0; l2_len = 64'h0000_0000_0000_0102; l2_dbus = 32'hFFFF_FFFF;
      use_fifo = 1'b0; act_src = 0; ptr = 0;
      #2;
      chk("rst_valid", 32'(rr_valid), 32'd0);
      chk("rst_data", 32'(rr_data), 32'd0);
      chk("rst_rdreq", 32'(rr_rdreq), 32'd0);
      chk("rst_busy", 32'(rr_busy), 32'd0);
      chk("rst_cur_src", 32'(rr_src), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Single frames from the vector table
      for (int t = 0; t < 5; t++) begin
         act_src = int'(vecs[t].src); use_fifo = 1'b1; ptr = 0;
         for (int b = 0; b < 8; b++) fifo_b[b] = 8'h00;
         fifo_b[0] = vecs[t].data[7:0]; fifo_b[1] = vecs[t].data[15:8]; fifo_b[2] = vecs[t].data[23:16];
         len_bus = 32'h0; len_bus[8*act_src +: 8] = vecs[t].len;
         drive_data();
         have_msg = 4'b0001 << act_src;
         run_rr(vecs[t].n, vecs[t].stall, 1'b1, 0);
         for (int b = 0; b < vecs[t].n; b++)
            chk($sformatf("vec%0d_byte%0d", t, b), 32'(got[b]), 32'(vecs[t].frame[63-8*b -: 8]));
         chk($sformatf("vec%0d_pops", t), 32'(pops), 32'(vecs[t].len));
         chk($sformatf("vec%0d_cur_src", t), 32'(rr_src), 32'(vecs[t].src));
         @(negedge clk); #1;
         chk($sformatf("vec%0d_idle_valid", t), 32'(rr_valid), 32'd0);
         chk($sformatf("vec%0d_idle_busy", t), 32'(rr_busy), 32'd0);
      end

      // All sources requesting, len 1: round-robin vs fixed priority, back-to-back
      do_reset();
      use_fifo = 1'b0; act_src = -1; len_bus = 32'h01010101; drive_data();
      have_msg = 4'hF;
      run_rr(30, 1'b0, 1'b0, 25);
      chk("rr_gaps", 32'(gaps), 32'd0);
      chk("fx_count", 32'(fx_got.size()), 32'd30);
      for (int f = 0; f < 5; f++) begin
         chk($sformatf("rr_frame%0d_prefix", f), 32'(got[6*f]), 32'h A5);
         chk($sformatf("rr_frame%0d_src", f), 32'(got[6*f+2]), 32'(f % 4));
         chk($sformatf("rr_frame%0d_chk", f), 32'(got[6*f+5]), 32'(8'h40 + 8'(f % 4)));
         chk($sformatf("fx_frame%0d_src", f), 32'(fx_got[6*f+2]), 32'd0);
      end
      chk("rr_pops", 32'(pops), 32'd5);
      @(negedge clk); #1;
      chk("rr_end_valid", 32'(rr_valid), 32'd0);

      // 16-bit length, XOR checksum over 258 bytes of FF
      do_reset();
      begin
         int k; int l2_pops; int ff_cnt;
         k = 0; l2_pops = 0; ff_cnt = 0; l2b.delete();
         l2_have = 4'b0001;
         while (l2b.size() < 264 && k < 3000) begin
            @(negedge clk); #1;
            if (l2_busy) l2_have = 4'b0000;
            if (l2_rdreq != 4'b0000) l2_pops++;
            if (l2_valid && tx_ready) l2b.push_back(l2_data);
            k++;
         end
         chk("l2_timeout", 32'(k >= 3000), 32'd0);
         for (int b = 5; b < 263; b++) if (l2b[b] == 8'hFF) ff_cnt++;
         chk("l2_prefix", 32'(l2b[0]), 32'hA5);
         chk("l2_src", 32'(l2b[2]), 32'h00);
         chk("l2_len_hi", 32'(l2b[3]), 32'h01);
         chk("l2_len_lo", 32'(l2b[4]), 32'h02);
         chk("l2_data_cnt", 32'(ff_cnt), 32'd258);
         chk("l2_chk", 32'(l2b[263]), 32'h00);
         chk("l2_pops", 32'(l2_pops), 32'd258);
         @(negedge clk); #1;
         chk("l2_end_busy", 32'(l2_busy), 32'd0);
      end

      // Reset in the middle of the data phase, then a fresh frame
      do_reset();
      use_fifo = 1'b0; act_src = 0; len_bus = 32'h00000005; drive_data();
      have_msg = 4'b0001;
      run_rr(6, 1'b0, 1'b1, 0);
      chk("pre_rst_rdreq", 32'(rr_rdreq), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(rr_valid), 32'd0);
      chk("mid_rst_rdreq", 32'(rr_rdreq), 32'd0);
      chk("mid_rst_busy", 32'(rr_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0; len_bus = 32'h00000001; have_msg = 4'b0001;
      run_rr(6, 1'b0, 1'b1, 0);
      chk("post_rst_prefix", 32'(got[0]), 32'hA5);
      chk("post_rst_src", 32'(got[2]), 32'h00);
      chk("post_rst_len", 32'(got[3]), 32'h01);
      chk("post_rst_chk", 32'(got[5]), 32'h40);
      chk("post_rst_pops", 32'(pops), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
